// File: rtl/arith_pkg.sv
// ----------------------------------------------------------------------------
// arith_pkg
//   Shared constants and helpers for the arithmetic component library.
//
//   MUL_DEFAULT_WIDTH : default operand width of the unsigned multiplier leaf
//   prod_width(w)     : full-width product size for two w-bit operands
// ----------------------------------------------------------------------------
package arith_pkg;

    localparam int MUL_DEFAULT_WIDTH = 4;

    // Operand width bounds the multiplier array is built for.
    localparam int MUL_MIN_WIDTH = 2;
    localparam int MUL_MAX_WIDTH = 16;

    // An unsigned w x w product never needs more than 2*w bits.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage : arith_pkg

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//   One-bit full adder cell used to build the multiplier's adder array.
//
//   Ports:
//     a, b  : addend bits
//     cin   : carry in
//     s     : sum bit
//     cout  : carry out
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/multiplier_4bu.sv
// ----------------------------------------------------------------------------
// multiplier_4bu
//   Clocked unsigned array multiplier. An AND-gate partial-product array is
//   reduced by WIDTH-1 rows of ripple-carry full adders; the exact 2*WIDTH-bit
//   product is captured in an output register together with a valid flag.
//   Latency 1 cycle, throughput 1 product per cycle, no backpressure.
//
//   Parameters:
//     WIDTH     : operand width, 2..16 (default 4)
//
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset (p and out_valid forced to 0)
//     in_valid  : sample a/b on this rising edge
//     a, b      : unsigned operands, WIDTH bits
//     p         : registered product a*b, 2*WIDTH bits
//     out_valid : high for one cycle when p holds a newly computed product
// ----------------------------------------------------------------------------
module multiplier_4bu
    import arith_pkg::*;
#(
    parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    output logic [prod_width(WIDTH)-1:0] p,
    output logic                         out_valid
);

    localparam int PW = prod_width(WIDTH);

    // ------------------------------------------------------------------
    // Partial products: pp[i][j] = a[j] & b[i]
    // ------------------------------------------------------------------
    logic [WIDTH-1:0][WIDTH-1:0] pp;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp_row
            for (genvar gj = 0; gj < WIDTH; gj++) begin : g_pp_col
                assign pp[gi][gj] = a[gj] & b[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Adder array.
    //   acc[i] is the WIDTH+1 bit running sum after row i, aligned so that
    //   its bit 0 has weight 2^i. Bit 0 is final at that point and becomes
    //   product bit i; bits WIDTH:1 are carried into the next row, where
    //   pp[i] (already at weight 2^i relative to that window) is added by a
    //   WIDTH-bit ripple-carry adder. The last row's full result forms the
    //   top WIDTH+1 product bits.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0][WIDTH:0] acc;
    logic [PW-1:0]             prod_d;

    assign acc[0] = {1'b0, pp[0]};

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_add_row
            logic [WIDTH:0]   carry;
            logic [WIDTH-1:0] sum;

            assign carry[0] = 1'b0;

            for (genvar gj = 0; gj < WIDTH; gj++) begin : g_add_col
                full_adder u_fa (
                    .a    (acc[gi-1][gj+1]),
                    .b    (pp[gi][gj]),
                    .cin  (carry[gj]),
                    .s    (sum[gj]),
                    .cout (carry[gj+1])
                );
            end

            assign acc[gi] = {carry[WIDTH], sum};
        end
    endgenerate

    // Low product bits retire one per row; the final row supplies the rest.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_low_bits
            assign prod_d[gi] = acc[gi][0];
        end
    endgenerate

    assign prod_d[PW-1:WIDTH-1] = acc[WIDTH-1];

    // ------------------------------------------------------------------
    // Output register. p only moves on an accepted sample, so it holds
    // the last product while in_valid is low.
    // ------------------------------------------------------------------
    logic [PW-1:0] p_q;
    logic          out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                p_q <= prod_d;
            end
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;

endmodule : multiplier_4bu

// File: tb/tb_multiplier_4bu.sv
module tb_multiplier_4bu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v4, v8;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic        ov4, ov8;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what the outputs should be after the last edge.
    logic [7:0]  exp_p4;
    logic        exp_v4;
    logic [15:0] exp_p8;
    logic        exp_v8;

    always #5 clk = ~clk;

    multiplier_4bu #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4),
        .a(a4), .b(b4), .p(p4), .out_valid(ov4)
    );

    multiplier_4bu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8),
        .a(a8), .b(b8), .p(p8), .out_valid(ov8)
    );

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic       v;
        logic [7:0] p;
        logic       ov;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // One cycle on the 4-bit unit: drive at the falling edge, check after
    // the rising edge against the arithmetic model.
    task automatic step4(input logic [3:0] ta, input logic [3:0] tb_, input logic tv);
        @(negedge clk);
        a4 = ta; b4 = tb_; v4 = tv;
        @(posedge clk);
        #1;
        if (tv) exp_p4 = 8'(int'(ta) * int'(tb_));
        exp_v4 = tv;
    endtask

    task automatic step8(input logic [7:0] ta, input logic [7:0] tb_, input logic tv);
        @(negedge clk);
        a8 = ta; b8 = tb_; v8 = tv;
        @(posedge clk);
        #1;
        if (tv) exp_p8 = 16'(int'(ta) * int'(tb_));
        exp_v8 = tv;
    endtask

    initial begin
        rst_n = 1'b0;
        v4 = 1'b0; a4 = '0; b4 = '0;
        v8 = 1'b0; a8 = '0; b8 = '0;
        exp_p4 = '0; exp_v4 = 1'b0;
        exp_p8 = '0; exp_v8 = 1'b0;

        // Directed table: sweep, corners, hold.
        vecs.push_back('{"sweep a0", 4'd0, 4'd7, 1'b1, 8'h00, 1'b1});
        vecs.push_back('{"sweep a1", 4'd1, 4'd7, 1'b1, 8'h07, 1'b1});
        vecs.push_back('{"sweep a2", 4'd2, 4'd7, 1'b1, 8'h0E, 1'b1});
        vecs.push_back('{"sweep a3", 4'd3, 4'd7, 1'b1, 8'h15, 1'b1});
        vecs.push_back('{"15x15",    4'd15, 4'd15, 1'b1, 8'hE1, 1'b1});
        vecs.push_back('{"15x0",     4'd15, 4'd0,  1'b1, 8'h00, 1'b1});
        vecs.push_back('{"1x15",     4'd1,  4'd15, 1'b1, 8'h0F, 1'b1});
        vecs.push_back('{"8x8",      4'd8,  4'd8,  1'b1, 8'h40, 1'b1});
        vecs.push_back('{"hold ld",  4'd5,  4'd3,  1'b1, 8'h0F, 1'b1});
        vecs.push_back('{"hold off", 4'd9,  4'd9,  1'b0, 8'h0F, 1'b0});
        vecs.push_back('{"hold off2",4'd12, 4'd6,  1'b0, 8'h0F, 1'b0});

        repeat (2) @(posedge clk);
        #1;
        chk("reset p4",  {8'h0, p4}, 16'h0);
        chk("reset ov4", {15'h0, ov4}, 16'h0);
        chk("reset p8",  p8, 16'h0);
        chk("reset ov8", {15'h0, ov8}, 16'h0);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step4(vecs[i].a, vecs[i].b, vecs[i].v);
            chk({vecs[i].name, " p"},  {8'h0, p4}, {8'h0, vecs[i].p});
            chk({vecs[i].name, " ov"}, {15'h0, ov4}, {15'h0, vecs[i].ov});
        end

        // Mid-run reset with a live 15x15 sample pending.
        step4(4'd3, 4'd4, 1'b1);
        chk("pre-reset p", {8'h0, p4}, 16'h000C);
        @(negedge clk);
        a4 = 4'd15; b4 = 4'd15; v4 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst p",  {8'h0, p4}, 16'h0);
        chk("async rst ov", {15'h0, ov4}, 16'h0);
        @(posedge clk);
        #1;
        chk("in-rst p",  {8'h0, p4}, 16'h0);
        chk("in-rst ov", {15'h0, ov4}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst p",  {8'h0, p4}, 16'h00E1);
        chk("post-rst ov", {15'h0, ov4}, 16'h0001);
        exp_p4 = 8'hE1; exp_v4 = 1'b1;

        // Exhaustive back-to-back.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                step4(4'(ia), 4'(ib), 1'b1);
                chk($sformatf("exh %0dx%0d", ia, ib), {8'h0, p4}, {8'h0, exp_p4});
                if (ov4 !== 1'b1) chk("exh ov", {15'h0, ov4}, 16'h1);
            end
        end

        // Randomised operands and gaps in in_valid.
        for (int k = 0; k < 60; k++) begin
            step4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            chk($sformatf("rnd%0d p", k),  {8'h0, p4}, {8'h0, exp_p4});
            chk($sformatf("rnd%0d ov", k), {15'h0, ov4}, {15'h0, exp_v4});
        end

        // Wider instance.
        step8(8'd255, 8'd255, 1'b1);
        chk("w8 255x255", p8, 16'hFE01);
        chk("w8 ov", {15'h0, ov8}, 16'h1);
        step8(8'd7, 8'd7, 1'b0);
        chk("w8 hold", p8, 16'hFE01);
        chk("w8 hold ov", {15'h0, ov8}, 16'h0);
        for (int k = 0; k < 40; k++) begin
            step8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            chk($sformatf("w8 rnd%0d p", k),  p8, exp_p8);
            chk($sformatf("w8 rnd%0d ov", k), {15'h0, ov8}, {15'h0, exp_v8});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_multiplier_4bu
